core_tx_serializer: RTL
=======================

# core_tx_serializer

Transmit-side endpoint for the processing core's output channel. It takes 16-bit words from the core's `data_out`/`data_out_valid` handshake and buffers them in a small FIFO. Each word is serialized onto a single-wire line (start bit, 16 data bits LSB first, stop bit). A one-cycle `tx_done` pulse returns to the core for every word that has fully left the line. It sits between the core and the chip output pad.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 2..255.
- `FIFO_DEPTH`, default 4: word buffer depth; must be a power of two, minimum 2.

Ports:
- `clk`  input  1  sole clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data_in`  input  16  word from core (core's `data_out`).
- `data_in_valid`  input  1  word valid (core's `data_out_valid`).
- `tx_ready`  output  1  FIFO can accept a word this cycle.
- `tx_done`  output  1  one-cycle pulse per completed frame (to core's `tx_done`).
- `serial_out`  output  1  line; idles high.
- `tx_busy`  output  1  frame in progress or FIFO non-empty.
- `overflow`  output  1  sticky; a valid word arrived while `tx_ready`=0.

## Operation

- **Reset values:** `serial_out`=1, `tx_done`=0, `tx_busy`=0, `overflow`=0, `tx_ready`=1. The FIFO is emptied, the FSM goes to IDLE, and all counters are cleared.
- **Accept:** a word is written when `data_in_valid && tx_ready` at a rising edge.
  - `tx_ready = (count != FIFO_DEPTH)`. It is combinational from the registered count.
  - `data_in_valid` with `tx_ready`=0 drops the word and sets `overflow` until reset.
- **FSM states:** IDLE, START, DATA, STOP. Each transition is listed with its line level:
  - IDLE → START when the FIFO is non-empty. The head word is popped into a 16-bit shift register and `serial_out` goes to 0.
  - START (line 0) → DATA after `CLKS_PER_BIT` cycles.
  - DATA: drive `shift[0]`. Shift right every `CLKS_PER_BIT` cycles. After 16 bits, go to STOP.
  - STOP (line 1) lasts `CLKS_PER_BIT` cycles. At its end, pulse `tx_done` and go to START if the FIFO is non-empty (popping in the same cycle, back-to-back with no idle gap), otherwise to IDLE.
- **Counters:**
  - bit-time counter: `$clog2(CLKS_PER_BIT)` bits, wraps to 0 at `CLKS_PER_BIT-1`.
  - bit index: 4 bits, 0..15.
  - FIFO count: `$clog2(FIFO_DEPTH)+1` bits.
- **FIFO pointers** wrap modulo `FIFO_DEPTH`.
- **`tx_busy`** = (state != IDLE) || (count != 0).

## Timing

- **Accept to line:** word accepted at edge E0 into an empty FIFO with FSM idle. The pop happens at E1 and `serial_out` falls at E1.
  - Latency is 1 cycle to the start bit.
- **Frame:** 18×`CLKS_PER_BIT` cycles.
  - `tx_done` is high for exactly the cycle after edge E1+18×`CLKS_PER_BIT`.
  - With default parameters that is E1+72.
- **Simultaneous push and pop:**
  - Both occur and the count is unchanged.
  - A push to a full FIFO is refused even if a pop happens in the same cycle, since `tx_ready` is not bypassed.
- **Empty FIFO:** a push to an empty FIFO while the FSM is in STOP is popped at the end of STOP. Frames stay back-to-back.
- **Reset mid-frame:** `serial_out`=1 in the cycle after the reset edge. No `tx_done` is produced for the aborted word. Buffered words are discarded.
- **Core contract:** the core must hold each word valid for only one cycle per accepted word. Repeated valid cycles are separate words.

## Structure

- **Shared package `core_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, STOP), 2 bits.
  - `WORD_W`=16 and `FRAME_BITS`=18.
  - Start/stop level constants.
- **One sub-module, `sync_fifo`:** parameterized width and depth, synchronous active-high reset, outputs `full`/`empty`/`count`, with first-word data available on the read port.
- **Serializer FSM and counters** live in `core_tx_serializer`.

## Test plan

- **Single word:** default parameters; reset, then push 0xA5C3 for one cycle.
  - `serial_out` is 0 for 4 cycles, then the bits are 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles, then 1 for 4 cycles.
  - `tx_done` pulses once at E1+72, and `tx_busy` falls with it.
- **Back-to-back:** push 0x0001, 0xFFFF, 0x8000 on consecutive cycles.
  - Three frames with no idle gap.
  - `tx_done` pulses at E1+72, +144 and +216.
  - `tx_ready` stays 1 throughout.
- **Overflow:** with FIFO_DEPTH=4, push 6 words on consecutive cycles starting from idle.
  - Words 1–5 are accepted: one is popped at E1 and four are buffered.
  - `tx_ready` goes 0 after the fifth.
  - The sixth is dropped and `overflow`=1.
  - Exactly five frames are transmitted.
- **Reset mid-frame:** push 0x1234, then assert `rst` during data bit 5.
  - `serial_out`=1 in the next cycle.
  - No `tx_done` pulse.
  - `tx_busy`=0 and `overflow`=0.
  - A fresh 0x5678 push afterwards transmits correctly.
- **Slow rate:** with CLKS_PER_BIT=7, push 0x00FF.
  - The frame lasts 126 cycles.
  - Each bit is held exactly 7 cycles.
  - `tx_done` fires at E1+126.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's transmit path.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   WORD_W     = 16;
    localparam int   FRAME_BITS = 18;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;
    localparam logic IDLE_LVL   = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == {CW{1'b0}});
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/core_tx_serializer.sv
// Buffers 16-bit words from the core and sends each as start + 16 data bits
// (LSB first) + stop on a single wire, pulsing tx_done per completed frame.
module core_tx_serializer
    import core_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              serial_out,
    output logic              tx_busy,
    output logic              overflow
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] fifo_rd_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic              pop_s;
    logic              bit_end_s;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_in_valid),
        .wr_data (data_in),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign tx_ready   = (fifo_count_s != CW'(FIFO_DEPTH));
    assign tx_busy    = (state_q != IDLE) || (fifo_count_s != {CW{1'b0}});
    assign tx_done    = done_q;
    assign serial_out = serial_q;
    assign overflow   = ovf_q;
    assign bit_end_s  = (tick_q == TICK_LAST);

    // Next-state logic: frame sequencing, bit timing and line level.
    always_comb begin
        state_d   = state_q;
        tick_d    = bit_end_s ? {TW{1'b0}} : tick_q + TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        pop_s     = 1'b0;
        ovf_d     = ovf_q || (data_in_valid && !tx_ready);

        case (state_q)
            IDLE: begin
                tick_d    = {TW{1'b0}};
                bit_idx_d = 4'd0;
                if (!fifo_empty_s) begin
                    state_d  = START;
                    pop_s    = 1'b1;
                    shift_d  = fifo_rd_data_s;
                    serial_d = START_LVL;
                end else begin
                    serial_d = IDLE_LVL;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_idx_d = 4'd0;
                    serial_d  = shift_q[0];
                end else begin
                    serial_d = START_LVL;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_q == 4'd15)) begin
                    state_d  = STOP;
                    serial_d = STOP_LVL;
                end else if (bit_end_s) begin
                    shift_d   = shift_q >> 1;
                    serial_d  = shift_q[1];
                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    serial_d = shift_q[0];
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    done_d = 1'b1;
                    // Re-arm straight into START so consecutive frames have no idle gap.
                    if (!fifo_empty_s) begin
                        state_d  = START;
                        pop_s    = 1'b1;
                        shift_d  = fifo_rd_data_s;
                        serial_d = START_LVL;
                    end else begin
                        state_d  = IDLE;
                        serial_d = IDLE_LVL;
                    end
                end else begin
                    serial_d = STOP_LVL;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = IDLE_LVL;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= {TW{1'b0}};
            bit_idx_q <= 4'd0;
            shift_q   <= {WORD_W{1'b0}};
            serial_q  <= IDLE_LVL;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
